pmod_walker: RTL and testbench

- Parametrised one-hot "walking light" driver for the PMOD pins on the iCEBreaker-bitsy.
- Advances the lit channel by a debounced button press (forward or reverse), by an internal auto-run timer, or in a bounce/ping-pong pattern.
- Supersedes the fixed 24-pin, non-debounced press stepper.
- Sits directly between the board pins (CLK, RST_N, BTN_N) and the PMOD output bus.

---
 rtl/pmod_walker_pkg.sv | 20 ++
 rtl/pmod_walker_if.sv | 15 +
 rtl/pmod_walker_debounce.sv | 57 +++++
 rtl/pmod_walker.sv | 143 ++++++++++++++
 tb/tb_pmod_walker.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pmod_walker_pkg.sv
// Shared constants for the PMOD walking-light driver: mode encodings,
// bounce direction type and a helper for the position register width.
package pmod_walker_pkg;

    localparam logic [1:0] MODE_FWD    = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_REV    = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // A single channel still needs a one-bit position register.
    function automatic int pos_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pmod_walker_if.sv
// Board-side bundle of the walker: mode select in, one-hot PMOD bus,
// press strobe and debounced LED level out.
interface pmod_walker_if #(
    parameter int CHANNELS = 24
);

    logic [1:0]          MODE;
    logic [CHANNELS-1:0] OUT;
    logic                STEP_PULSE;
    logic                LEDG_N;

    modport master (output MODE, input OUT, STEP_PULSE, LEDG_N);
    modport slave  (input MODE, output OUT, STEP_PULSE, LEDG_N);

endinterface

// File: rtl/pmod_walker_debounce.sv
// Button conditioning for the walker: two-flop synchroniser on the raw
// active-low button, a stable-count debouncer and a press edge strobe.
module button_debounce #(
    parameter int LOG2 = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_N,
    output logic level_n,
    output logic press_pulse
);

    localparam logic [LOG2-1:0] COUNT_MAX = '1;

    logic            sync1;
    logic            sync2;
    logic            level_d;
    logic [LOG2-1:0] count;

    // Bring the asynchronous button into the CLK domain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= BTN_N;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for 2^LOG2 cycles in a row.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_n <= 1'b1;
            count   <= '0;
        end else if (sync2 == level_n) begin
            count <= '0;
        end else if (count == COUNT_MAX) begin
            level_n <= sync2;
            count   <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Strobe for one cycle after the debounced level falls; release is silent.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_d     <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            level_d     <= level_n;
            press_pulse <= level_d & ~level_n;
        end
    end

endmodule

// File: rtl/pmod_walker.sv
// One-hot walking light for the iCEBreaker-bitsy PMOD pins. Steps on a
// debounced press (forward or reverse), on a free-running auto timer, or
// ping-pongs between the end channels.
// Optional build macro PMOD_WALKER_PAUSE_EN: a press in auto/bounce modes
// toggles a pause flag that suppresses timer steps.
module pmod_walker
    import pmod_walker_pkg::*;
#(
    parameter int CHANNELS      = 24,
    parameter int DEBOUNCE_LOG2 = 16,
    parameter int AUTO_LOG2     = 20
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_N,
    pmod_walker_if.slave pmod
);

    localparam int               POS_W  = pos_width(CHANNELS);
    localparam logic [POS_W-1:0] ZERO   = '0;
    localparam logic [POS_W-1:0] ONE    = POS_W'(1);
    localparam logic [POS_W-1:0] LAST   = POS_W'(CHANNELS - 1);
    localparam logic [POS_W-1:0] PENULT = (CHANNELS > 1) ? POS_W'(CHANNELS - 2) : '0;

    logic                 step_pulse;
    logic                 level_n;
    logic [AUTO_LOG2-1:0] prescaler;
    logic                 tick;
    logic                 paused;
    logic [1:0]           mode_q;
    logic [POS_W-1:0]     pos;
    logic [POS_W-1:0]     pos_next;
    dir_t                 dir;
    dir_t                 dir_next;
    logic [CHANNELS-1:0]  out_q;

    function automatic logic [POS_W-1:0] step_fwd(input logic [POS_W-1:0] p);
        return (p == LAST) ? ZERO : p + ONE;
    endfunction

    function automatic logic [POS_W-1:0] step_rev(input logic [POS_W-1:0] p);
        return (p == ZERO) ? LAST : p - ONE;
    endfunction

    button_debounce #(
        .LOG2        (DEBOUNCE_LOG2)
    ) u_debounce (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .BTN_N       (BTN_N),
        .level_n     (level_n),
        .press_pulse (step_pulse)
    );

    assign tick = &prescaler;

    // Free-running step timer; mode changes leave its phase alone.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

`ifdef PMOD_WALKER_PAUSE_EN
    logic timed_mode;
    assign timed_mode = (pmod.MODE == MODE_AUTO) || (pmod.MODE == MODE_BOUNCE);

    // Press toggles pause in the timed modes; any manual mode clears it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            paused <= 1'b0;
        end else if (!timed_mode) begin
            paused <= 1'b0;
        end else if (step_pulse) begin
            paused <= ~paused;
        end
    end
`else
    assign paused = 1'b0;
`endif

    // Choose the next position and bounce direction from the mode's step source.
    always_comb begin
        pos_next = pos;
        dir_next = dir;
        case (pmod.MODE)
            MODE_FWD: begin
                if (step_pulse) pos_next = step_fwd(pos);
            end
            MODE_REV: begin
                if (step_pulse) pos_next = step_rev(pos);
            end
            MODE_AUTO: begin
                if (tick && !paused) pos_next = step_fwd(pos);
            end
            MODE_BOUNCE: begin
                if (mode_q != MODE_BOUNCE) begin
                    dir_next = DIR_UP;
                end else if (tick && !paused) begin
                    if (dir == DIR_UP) begin
                        if (pos == LAST) begin
                            dir_next = DIR_DOWN;
                            pos_next = PENULT;
                        end else begin
                            pos_next = pos + ONE;
                        end
                    end else begin
                        if (pos == ZERO) begin
                            dir_next = DIR_UP;
                            pos_next = ONE;
                        end else begin
                            pos_next = pos - ONE;
                        end
                    end
                end
            end
            default: ;
        endcase
        if (CHANNELS == 1) pos_next = ZERO;
    end

    // Position/direction state with the one-hot bus registered alongside it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pos    <= ZERO;
            dir    <= DIR_UP;
            mode_q <= MODE_FWD;
            out_q  <= CHANNELS'(1);
        end else begin
            pos    <= pos_next;
            dir    <= dir_next;
            mode_q <= pmod.MODE;
            out_q  <= CHANNELS'(1) << pos_next;
        end
    end

    assign pmod.OUT        = out_q;
    assign pmod.STEP_PULSE = step_pulse;
    assign pmod.LEDG_N     = level_n;

endmodule

// File: tb/tb_pmod_walker.sv
// Directed bench for pmod_walker with CHANNELS=5, DEBOUNCE_LOG2=2,
// AUTO_LOG2=3. Inputs change and outputs are sampled on the falling edge.
module tb_pmod_walker;
    import pmod_walker_pkg::*;

    logic CLK;
    logic RST_N;
    logic BTN_N;

    int compared   = 0;
    int mismatched = 0;

    pmod_walker_if #(.CHANNELS(5)) pif ();

    pmod_walker #(
        .CHANNELS      (5),
        .DEBOUNCE_LOG2 (2),
        .AUTO_LOG2     (3)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .BTN_N (BTN_N),
        .pmod  (pif)
    );

    // 10-unit clock, rising edges at 5, 15, 25 ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case some wait never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic btn, input logic [1:0] mode);
        BTN_N    = btn;
        pif.MODE = mode;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pressButton();
        BTN_N = 1'b0;
        cycles(10);
        BTN_N = 1'b1;
        cycles(10);
    endtask

    task automatic waitChange(input string tag, input int budget, output int waited);
        logic [4:0] prev;
        logic       timedOut;
        prev     = pif.OUT;
        waited   = budget;
        timedOut = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (pif.OUT !== prev) begin
                waited   = i;
                timedOut = 1'b0;
                break;
            end
        end
        checkOutput({tag, " timeout"}, 64'(timedOut), 64'd0);
    endtask

    initial begin
        int         waited;
        int         firstPulse;
        int         pulses;
        logic       sawPulse;
        logic       changed;
        logic [4:0] held;
        logic [4:0] expNext;
        logic [4:0] wrapOut [5]     = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        int         autoPos [8]     = '{1, 2, 3, 4, 0, 1, 2, 3};
        int         bouncePos [13]  = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3};

        // Reset and idle in manual-forward mode.
        RST_N = 1'b0;
        applyStimulus(1'b1, MODE_FWD);
        cycles(3);
        checkOutput("reset OUT", 64'(pif.OUT), 64'b00001);
        checkOutput("reset STEP_PULSE", 64'(pif.STEP_PULSE), 64'd0);
        checkOutput("reset LEDG_N", 64'(pif.LEDG_N), 64'd1);
        RST_N = 1'b1;
        cycles(3);
        checkOutput("idle OUT", 64'(pif.OUT), 64'b00001);
        checkOutput("idle STEP_PULSE", 64'(pif.STEP_PULSE), 64'd0);

        // Three-cycle glitch must be rejected.
        BTN_N    = 1'b0;
        sawPulse = 1'b0;
        cycles(3);
        BTN_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (pif.STEP_PULSE) sawPulse = 1'b1;
        end
        checkOutput("glitch no pulse", 64'(sawPulse), 64'd0);
        checkOutput("glitch OUT", 64'(pif.OUT), 64'b00001);
        checkOutput("glitch LEDG_N", 64'(pif.LEDG_N), 64'd1);

        // Ten-cycle press: one pulse on the 7th edge, OUT moves one edge later.
        BTN_N      = 1'b0;
        firstPulse = 0;
        pulses     = 0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge CLK);
            if (pif.STEP_PULSE) begin
                pulses++;
                if (firstPulse == 0) firstPulse = i;
            end
            if (i == 8) checkOutput("press OUT after pulse", 64'(pif.OUT), 64'b00010);
            if (i == 10) begin
                checkOutput("press LEDG_N low", 64'(pif.LEDG_N), 64'd0);
                BTN_N = 1'b1;
            end
        end
        checkOutput("press first pulse edge", 64'(firstPulse), 64'd7);
        checkOutput("press pulse count", 64'(pulses), 64'd1);
        checkOutput("release LEDG_N", 64'(pif.LEDG_N), 64'd1);
        checkOutput("release OUT", 64'(pif.OUT), 64'b00010);

        // Asynchronous reset between clock edges.
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async reset OUT", 64'(pif.OUT), 64'b00001);
        @(negedge CLK);
        RST_N = 1'b1;
        cycles(2);

        // Manual forward wraps after the last channel.
        for (int k = 0; k < 5; k++) begin
            pressButton();
            checkOutput($sformatf("wrap press %0d", k), 64'(pif.OUT), 64'(wrapOut[k]));
        end

        // Manual reverse from channel 0 wraps to the last channel.
        applyStimulus(1'b1, MODE_REV);
        pressButton();
        checkOutput("reverse wrap", 64'(pif.OUT), 64'b10000);
        applyStimulus(1'b1, MODE_FWD);
        pressButton();
        checkOutput("back to pos 0", 64'(pif.OUT), 64'b00001);

        // Auto-run: one step every 8 cycles.
        applyStimulus(1'b1, MODE_AUTO);
        for (int k = 0; k < 8; k++) begin
            waitChange($sformatf("auto %0d", k), 12, waited);
            checkOutput($sformatf("auto pos %0d", k), 64'(pif.OUT), 64'(5'b1 << autoPos[k]));
            if (k > 0) checkOutput($sformatf("auto period %0d", k), 64'(waited), 64'd8);
        end
        checkOutput("auto 8 ticks", 64'(pif.OUT), 64'b01000);

        // Return to channel 0 for the bounce run.
        applyStimulus(1'b1, MODE_FWD);
        pressButton();
        pressButton();
        checkOutput("bounce start", 64'(pif.OUT), 64'b00001);

        // Bounce: ping-pong with single-tick end channels.
        applyStimulus(1'b1, MODE_BOUNCE);
        for (int k = 0; k < 13; k++) begin
            waitChange($sformatf("bounce %0d", k), 12, waited);
            checkOutput($sformatf("bounce pos %0d", k), 64'(pif.OUT), 64'(5'b1 << bouncePos[k]));
        end

        // Re-entering bounce at pos 3 heading down restarts upward.
        applyStimulus(1'b1, MODE_FWD);
        cycles(3);
        checkOutput("bounce hold in fwd", 64'(pif.OUT), 64'b01000);
        applyStimulus(1'b1, MODE_BOUNCE);
        waitChange("bounce reentry", 12, waited);
        checkOutput("bounce reentry pos", 64'(pif.OUT), 64'b10000);

        applyStimulus(1'b1, MODE_AUTO);
        waitChange("auto sync", 12, waited);
        checkOutput("auto sync pos", 64'(pif.OUT), 64'b00001);
`ifdef PMOD_WALKER_PAUSE_EN
        // A press pauses the timer steps; a second press resumes them.
        pressButton();
        held    = pif.OUT;
        changed = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge CLK);
            if (pif.OUT !== held) changed = 1'b1;
        end
        checkOutput("paused hold", 64'(changed), 64'd0);
        expNext = (held == 5'b10000) ? 5'b00001 : (held << 1);
        BTN_N   = 1'b0;
        waitChange("resume", 16, waited);
        checkOutput("resume pos", 64'(pif.OUT), 64'(expNext));
        BTN_N = 1'b1;
        cycles(10);
`else
        // Without the pause feature a press leaves the timer stepping intact.
        BTN_N = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            waitChange($sformatf("press in auto %0d", k), 12, waited);
            checkOutput($sformatf("press in auto pos %0d", k), 64'(pif.OUT), 64'(5'b1 << k));
            checkOutput($sformatf("press in auto period %0d", k), 64'(waited), 64'd8);
            if (k == 2) BTN_N = 1'b1;
        end
        held    = pif.OUT;
        expNext = held;
        changed = 1'b0;
        checkOutput("press in auto LEDG_N", 64'(pif.LEDG_N), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
